// File: rtl/trigger_pkg.sv
`default_nettype none
// ============================================================================
// Module      : trigger_pkg
// Description : Shared constants for the multi-stage sequential trigger.
//               - Bit positions of the fields in the stage config word.
//               - FSM state encoding.
//               - Sizing of the stage index.
// Revision    : 1.0 - initial release
// ============================================================================
package trigger_pkg;

    // Stage config word field positions
    localparam int CFG_DLY_LSB   = 0;
    localparam int CFG_LVL_LSB   = 16;
    localparam int CFG_START_BIT = 27;
    localparam int CFG_EDGE_BIT  = 28;
    localparam int CFG_EN_BIT    = 31;

    // The config stage index is 3 bits wide, so at most 8 stages exist.
    // Arrays indexed by a stage number are sized to STG_MAX so that any
    // 3-bit index is in range.
    localparam int STG_MAX = 8;
    localparam int STG_IW  = 3;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_DELAY = 2'd2;
    localparam logic [1:0] ST_FIRED = 2'd3;

endpackage
`default_nettype wire

// File: rtl/trigger_stage.sv
`default_nettype none
// ============================================================================
// Module      : trigger_stage
// Description : One trigger stage.
//               - Holds the stage's mask, value and config registers.
//               - Produces an unqualified match bit for the sample presented.
//               - With TRIGGER_SEQ_EDGE_EN defined, a stage whose edge bit is
//                 set also requires that the previous accepted sample did NOT
//                 match under the same mask/value.
// Ports       : clk, rst (async, active-low)
//               cfg_stg/cfg_wr_*/cfg_data : configuration write interface
//               sample      : current input sample
//               prev_sample : previous accepted sample (edge build only)
//               level       : current sequencer level
//               match       : stage matches (not yet qualified by handshake)
//               delay/start : config fields used by the sequencer
// Revision    : 1.0 - initial release
// ============================================================================
module trigger_stage
    import trigger_pkg::*;
#(
    parameter int SDW = 32,
    parameter int DLW = 16,
    parameter int LVW = 2,
    parameter int IDX = 0
)(
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        cfg_stg,
    input  logic              cfg_wr_mask,
    input  logic              cfg_wr_val,
    input  logic              cfg_wr_cfg,
    input  logic [31:0]       cfg_data,
    input  logic [SDW-1:0]    sample,
`ifdef TRIGGER_SEQ_EDGE_EN
    input  logic [SDW-1:0]    prev_sample,
`endif
    input  logic [LVW-1:0]    level,
    output logic              match,
    output logic [DLW-1:0]    delay,
    output logic              start
);

    logic [SDW-1:0] cfg_sdw;
    logic [SDW-1:0] mask;
    logic [SDW-1:0] value;
    logic [LVW-1:0] stg_level;
    logic           enable;
    logic           sel;
    logic           hit_cur;
    logic           unused_cfg;

    // Only some config-word bits are stored; the rest are reserved.
    assign unused_cfg = ^cfg_data;

    // Samples wider than the config bus are zero-extended on write.
    if (SDW <= 32) begin : g_cfg_narrow
        assign cfg_sdw = cfg_data[SDW-1:0];
    end else begin : g_cfg_wide
        assign cfg_sdw = {{(SDW-32){1'b0}}, cfg_data};
    end

    assign sel = (cfg_stg == 3'(IDX));

`ifdef TRIGGER_SEQ_EDGE_EN
    logic edge_en;
    logic hit_prev;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mask      <= '0;
            value     <= '0;
            delay     <= '0;
            stg_level <= '0;
            start     <= 1'b0;
            enable    <= 1'b0;
`ifdef TRIGGER_SEQ_EDGE_EN
            edge_en   <= 1'b0;
`endif
        end else begin
            if (sel && cfg_wr_mask) begin
                mask <= cfg_sdw;
            end
            if (sel && cfg_wr_val) begin
                value <= cfg_sdw;
            end
            if (sel && cfg_wr_cfg) begin
                delay     <= cfg_data[CFG_DLY_LSB +: DLW];
                stg_level <= cfg_data[CFG_LVL_LSB +: LVW];
                start     <= cfg_data[CFG_START_BIT];
                enable    <= cfg_data[CFG_EN_BIT];
`ifdef TRIGGER_SEQ_EDGE_EN
                edge_en   <= cfg_data[CFG_EDGE_BIT];
`endif
            end
        end
    end

    assign hit_cur = (((sample ^ value) & mask) == '0);

`ifdef TRIGGER_SEQ_EDGE_EN
    assign hit_prev = (((prev_sample ^ value) & mask) == '0);
    assign match    = enable && (stg_level == level) && hit_cur
                      && !(edge_en && hit_prev);
`else
    assign match    = enable && (stg_level == level) && hit_cur;
`endif

endmodule
`default_nettype wire

// File: rtl/trigger_seq.sv
`default_nettype none
// ============================================================================
// Module      : trigger_seq
// Description : Parametrised multi-stage sequential trigger on a sample
//               stream. Forwards samples through a one-deep output register
//               and tags the sample on which the trigger fires.
//               Optional feature macro: TRIGGER_SEQ_EDGE_EN (edge-qualified
//               stage matching using the previous accepted sample).
// Ports       : clk, rst (async, active-low)
//               cfg_*      : stage configuration writes
//               ctl_arm    : clear level/delay and enter ARMED
//               ctl_clr    : return to IDLE
//               sti_*      : input stream (AXI-stream style)
//               sto_*      : output stream, sto_trigger marks firing sample
//               run        : one-cycle pulse when the trigger fires
//               sts_level  : current level
//               sts_armed  : state is ARMED or DELAY
// Revision    : 1.0 - initial release
// ============================================================================
module trigger_seq
    import trigger_pkg::*;
#(
    parameter int SDW = 32,
    parameter int STN = 4,
    parameter int DLW = 16,
    parameter int LVW = 2
)(
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        cfg_stg,
    input  logic              cfg_wr_mask,
    input  logic              cfg_wr_val,
    input  logic              cfg_wr_cfg,
    input  logic [31:0]       cfg_data,
    input  logic              ctl_arm,
    input  logic              ctl_clr,
    output logic              sti_tready,
    input  logic              sti_tvalid,
    input  logic              sti_tlast,
    input  logic [SDW-1:0]    sti_tdata,
    input  logic              sto_tready,
    output logic              sto_tvalid,
    output logic              sto_tlast,
    output logic              sto_trigger,
    output logic [SDW-1:0]    sto_tdata,
    output logic              run,
    output logic [LVW-1:0]    sts_level,
    output logic              sts_armed
);

    logic                 hs;
    logic [STG_MAX-1:0]   stg_match;
    logic [DLW-1:0]       stg_delay [STG_MAX];
    logic [STG_MAX-1:0]   stg_start;
    logic [STG_IW-1:0]    pe_idx;
    logic                 any_match;

    logic [1:0]           state;
    logic [1:0]           state_nxt;
    logic [LVW-1:0]       level;
    logic [LVW-1:0]       level_nxt;
    logic [DLW-1:0]       dly_cnt;
    logic [DLW-1:0]       dly_cnt_nxt;
    logic [STG_IW-1:0]    win;
    logic [STG_IW-1:0]    win_nxt;
    logic                 expire;
    logic [STG_IW-1:0]    exp_idx;
    logic                 fire;

    assign sti_tready = !sto_tvalid || sto_tready;
    assign hs         = sti_tvalid && sti_tready;

`ifdef TRIGGER_SEQ_EDGE_EN
    // Previous accepted sample, tracked in every state.
    logic [SDW-1:0] prev_sample;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_sample <= '0;
        end else if (hs) begin
            prev_sample <= sti_tdata;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Stages; unused slots up to STG_MAX read as never-matching.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < STG_MAX; i++) begin : g_stage
        if (i < STN) begin : g_inst
            trigger_stage #(
                .SDW (SDW),
                .DLW (DLW),
                .LVW (LVW),
                .IDX (i)
            ) u_stage (
                .clk         (clk),
                .rst         (rst),
                .cfg_stg     (cfg_stg),
                .cfg_wr_mask (cfg_wr_mask),
                .cfg_wr_val  (cfg_wr_val),
                .cfg_wr_cfg  (cfg_wr_cfg),
                .cfg_data    (cfg_data),
                .sample      (sti_tdata),
`ifdef TRIGGER_SEQ_EDGE_EN
                .prev_sample (prev_sample),
`endif
                .level       (level),
                .match       (stg_match[i]),
                .delay       (stg_delay[i]),
                .start       (stg_start[i])
            );
        end else begin : g_pad
            assign stg_match[i] = 1'b0;
            assign stg_delay[i] = '0;
            assign stg_start[i] = 1'b0;
        end
    end

    // Lowest-index matching stage wins.
    always_comb begin
        pe_idx = '0;
        for (int i = STG_MAX - 1; i >= 0; i--) begin
            if (stg_match[i]) begin
                pe_idx = STG_IW'(i);
            end
        end
    end

    assign any_match = |stg_match;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            level   <= '0;
            dly_cnt <= '0;
            win     <= '0;
        end else begin
            state   <= state_nxt;
            level   <= level_nxt;
            dly_cnt <= dly_cnt_nxt;
            win     <= win_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic. ctl_clr beats ctl_arm beats match/expiry.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt   = state;
        level_nxt   = level;
        dly_cnt_nxt = dly_cnt;
        win_nxt     = win;
        expire      = 1'b0;
        exp_idx     = win;
        fire        = 1'b0;

        if (ctl_clr) begin
            state_nxt = ST_IDLE;
        end else if (ctl_arm) begin
            state_nxt   = ST_ARMED;
            level_nxt   = '0;
            dly_cnt_nxt = '0;
        end else begin
            case (state)
                ST_ARMED: begin
                    if (hs && any_match) begin
                        win_nxt     = pe_idx;
                        dly_cnt_nxt = stg_delay[pe_idx];
                        if (stg_delay[pe_idx] == '0) begin
                            // Zero delay: expiry acts on this same sample.
                            expire  = 1'b1;
                            exp_idx = pe_idx;
                        end else begin
                            state_nxt = ST_DELAY;
                        end
                    end
                end
                ST_DELAY: begin
                    // Counts accepted samples, not clock cycles.
                    if (hs) begin
                        if (dly_cnt <= DLW'(1)) begin
                            dly_cnt_nxt = '0;
                            expire      = 1'b1;
                        end else begin
                            dly_cnt_nxt = dly_cnt - DLW'(1);
                        end
                    end
                end
                default: begin
                end
            endcase

            if (expire) begin
                if (stg_start[exp_idx]) begin
                    fire      = 1'b1;
                    state_nxt = ST_FIRED;
                end else begin
                    state_nxt = ST_ARMED;
                    if (level != {LVW{1'b1}}) begin
                        level_nxt = level + LVW'(1);
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        sts_armed = (state == ST_ARMED) || (state == ST_DELAY);
        sts_level = level;
    end

    // ------------------------------------------------------------------
    // Stream register. fire only occurs on a handshake, so the trigger
    // tag always lands with the sample that caused it.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sto_tvalid  <= 1'b0;
            sto_tlast   <= 1'b0;
            sto_trigger <= 1'b0;
            sto_tdata   <= '0;
            run         <= 1'b0;
        end else begin
            run <= fire;
            if (sti_tready) begin
                sto_tvalid  <= sti_tvalid;
                sto_tdata   <= sti_tdata;
                sto_tlast   <= sti_tlast;
                sto_trigger <= fire;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_trigger_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_trigger_seq
// Description : Self-checking bench for trigger_seq. A sample-level model
//               of the trigger rules runs alongside the DUT and is compared
//               every cycle; directed tests add literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trigger_seq;

    localparam int SDW = 32;
    localparam int STN = 4;
    localparam int DLW = 16;
    localparam int LVW = 2;
    localparam int LVMAX = (1 << LVW) - 1;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [2:0]      cfg_stg = 3'd0;
    logic            cfg_wr_mask = 1'b0;
    logic            cfg_wr_val = 1'b0;
    logic            cfg_wr_cfg = 1'b0;
    logic [31:0]     cfg_data = 32'd0;
    logic            ctl_arm = 1'b0;
    logic            ctl_clr = 1'b0;
    logic            sti_tready;
    logic            sti_tvalid = 1'b0;
    logic            sti_tlast = 1'b0;
    logic [SDW-1:0]  sti_tdata = '0;
    logic            sto_tready = 1'b1;
    logic            sto_tvalid;
    logic            sto_tlast;
    logic            sto_trigger;
    logic [SDW-1:0]  sto_tdata;
    logic            run;
    logic [LVW-1:0]  sts_level;
    logic            sts_armed;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    trigger_seq #(.SDW(SDW), .STN(STN), .DLW(DLW), .LVW(LVW)) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_stg     (cfg_stg),
        .cfg_wr_mask (cfg_wr_mask),
        .cfg_wr_val  (cfg_wr_val),
        .cfg_wr_cfg  (cfg_wr_cfg),
        .cfg_data    (cfg_data),
        .ctl_arm     (ctl_arm),
        .ctl_clr     (ctl_clr),
        .sti_tready  (sti_tready),
        .sti_tvalid  (sti_tvalid),
        .sti_tlast   (sti_tlast),
        .sti_tdata   (sti_tdata),
        .sto_tready  (sto_tready),
        .sto_tvalid  (sto_tvalid),
        .sto_tlast   (sto_tlast),
        .sto_trigger (sto_trigger),
        .sto_tdata   (sto_tdata),
        .run         (run),
        .sts_level   (sts_level),
        .sts_armed   (sts_armed)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", nm, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: one step per clock, working on whole samples.
    // mode: 0 idle, 1 armed, 2 waiting out a delay, 3 fired.
    // ------------------------------------------------------------------
    logic [SDW-1:0] m_mask [STN];
    logic [SDW-1:0] m_val  [STN];
    logic [31:0]    m_cfg  [STN];
    int             m_mode = 0;
    int             m_level = 0;
    int             m_rem = 0;
    int             m_win = 0;
    int             n_acc = 0;
    logic           m_hs = 1'b0;
    logic           m_ovalid = 1'b0;
    logic           m_olast = 1'b0;
    logic           m_otrig = 1'b0;
    logic           m_run = 1'b0;
    logic [SDW-1:0] m_odata = '0;
    logic [SDW-1:0] m_prev = '0;

    function automatic bit stage_hits(input int i, input logic [SDW-1:0] d);
        bit cur;
        cur = (((d ^ m_val[i]) & m_mask[i]) == '0);
        if (!m_cfg[i][31]) return 1'b0;
        if (int'(m_cfg[i][17:16]) != m_level) return 1'b0;
`ifdef TRIGGER_SEQ_EDGE_EN
        if (m_cfg[i][28] && (((m_prev ^ m_val[i]) & m_mask[i]) == '0)) return 1'b0;
`endif
        return cur;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < STN; i++) begin
                m_mask[i] = '0;
                m_val[i]  = '0;
                m_cfg[i]  = '0;
            end
            m_mode = 0; m_level = 0; m_rem = 0; m_win = 0;
            m_hs = 1'b0; m_ovalid = 1'b0; m_olast = 1'b0; m_otrig = 1'b0;
            m_run = 1'b0; m_odata = '0; m_prev = '0;
        end else begin : step
            automatic bit fire = 1'b0;
            automatic bit expire = 1'b0;
            automatic int hit = -1;
            m_hs = sti_tvalid && (!m_ovalid || sto_tready);
            if (ctl_clr) begin
                m_mode = 0;
            end else if (ctl_arm) begin
                m_mode = 1; m_level = 0; m_rem = 0;
            end else if (m_hs && m_mode == 1) begin
                for (int i = STN - 1; i >= 0; i--) begin
                    if (stage_hits(i, sti_tdata)) hit = i;
                end
                if (hit >= 0) begin
                    m_win = hit;
                    m_rem = int'(m_cfg[hit][15:0]);
                    if (m_rem == 0) expire = 1'b1;
                    else m_mode = 2;
                end
            end else if (m_hs && m_mode == 2) begin
                m_rem--;
                if (m_rem <= 0) begin
                    m_rem = 0;
                    expire = 1'b1;
                end
            end
            if (expire) begin
                if (m_cfg[m_win][27]) begin
                    fire = 1'b1;
                    m_mode = 3;
                end else begin
                    m_mode = 1;
                    if (m_level < LVMAX) m_level++;
                end
            end
            if (!m_ovalid || sto_tready) begin
                m_ovalid = sti_tvalid;
                if (sti_tvalid) begin
                    m_odata = sti_tdata;
                    m_olast = sti_tlast;
                    m_otrig = fire;
                end
            end
            m_run = fire;
            if (m_hs) begin
                m_prev = sti_tdata;
                n_acc++;
            end
            if (int'(cfg_stg) < STN) begin
                if (cfg_wr_mask) m_mask[cfg_stg] = cfg_data[SDW-1:0];
                if (cfg_wr_val)  m_val[cfg_stg]  = cfg_data[SDW-1:0];
                if (cfg_wr_cfg)  m_cfg[cfg_stg]  = cfg_data;
            end
        end
    end

    // Every-cycle comparison against the model, just after the active edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                chk("tvalid", sto_tvalid, m_ovalid);
                chk("tready", sti_tready, !m_ovalid || sto_tready);
                chk("run", run, m_run);
                chk("level", sts_level, m_level);
                chk("armed", sts_armed, (m_mode == 1) || (m_mode == 2));
                if (m_ovalid) begin
                    chk("tdata", sto_tdata, m_odata);
                    chk("tlast", sto_tlast, m_olast);
                    chk("trigger", sto_trigger, m_otrig);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic cfg_wr(input int stg, input int kind, input logic [31:0] d);
        @(negedge clk);
        cfg_stg     = 3'(stg);
        cfg_data    = d;
        cfg_wr_mask = (kind == 0);
        cfg_wr_val  = (kind == 1);
        cfg_wr_cfg  = (kind == 2);
        @(negedge clk);
        cfg_wr_mask = 1'b0;
        cfg_wr_val  = 1'b0;
        cfg_wr_cfg  = 1'b0;
    endtask

    task automatic set_stage(input int stg, input logic [31:0] mask,
                             input logic [31:0] val, input logic [31:0] cfg);
        cfg_wr(stg, 0, mask);
        cfg_wr(stg, 1, val);
        cfg_wr(stg, 2, cfg);
    endtask

    task automatic pulse(input bit arm, input bit clr);
        @(negedge clk);
        ctl_arm = arm;
        ctl_clr = clr;
        @(negedge clk);
        ctl_arm = 1'b0;
        ctl_clr = 1'b0;
    endtask

    // Presents one sample, waits for its handshake, returns at the following
    // negedge with valid dropped; outputs then still show that handshake.
    task automatic send(input logic [SDW-1:0] d, input logic l);
        bit done = 1'b0;
        @(negedge clk);
        sti_tvalid = 1'b1;
        sti_tdata  = d;
        sti_tlast  = l;
        for (int k = 0; k < 50 && !done; k++) begin
            @(posedge clk);
            #1;
            done = m_hs;
        end
        if (!done) begin
            checks++;
            fails++;
            $display("FAIL send_timeout: sample %0h not accepted in 50 cycles", d);
        end
        @(negedge clk);
        sti_tvalid = 1'b0;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int start_acc;
        bit ok;
        repeat (3) @(negedge clk);
        chk("rst_tvalid", sto_tvalid, 0);
        chk("rst_run", run, 0);
        chk("rst_armed", sts_armed, 0);
        chk("rst_level", sts_level, 0);
        rst = 1'b1;

        // ---- single-stage immediate fire
        set_stage(0, 32'hFF, 32'h5A, 32'h8800_0000);
        pulse(1'b1, 1'b0);
        chk("t1_armed", sts_armed, 1);
        send(32'h00, 1'b0);
        send(32'h11, 1'b0);
        chk("t1_no_trig", sto_trigger, 0);
        chk("t1_no_run", run, 0);
        send(32'h5A, 1'b1);
        chk("t1_run", run, 1);
        chk("t1_trig", sto_trigger, 1);
        chk("t1_data", sto_tdata, 32'h5A);
        chk("t1_fired", sts_armed, 0);
        @(negedge clk);
        chk("t1_run_pulse", run, 0);

        // ---- two-level sequence
        set_stage(0, 32'hFF, 32'h01, 32'h8000_0000);
        set_stage(1, 32'hFF, 32'h02, 32'h8801_0000);
        pulse(1'b1, 1'b0);
        send(32'h02, 1'b0);
        chk("t2_lvl0", sts_level, 0);
        chk("t2_run0", run, 0);
        send(32'h01, 1'b0);
        chk("t2_lvl1", sts_level, 1);
        chk("t2_armed", sts_armed, 1);
        send(32'h02, 1'b0);
        chk("t2_run", run, 1);

        // ---- delay of 3 samples with a backpressure stall in the middle
        set_stage(1, 32'h0, 32'h0, 32'h0);
        set_stage(0, 32'hFF, 32'h33, 32'h8800_0003);
        pulse(1'b1, 1'b0);
        send(32'h33, 1'b0);
        chk("t3_n0_run", run, 0);
        chk("t3_n0_armed", sts_armed, 1);
        send(32'h40, 1'b0);
        sto_tready = 1'b0;
        fork
            begin
                repeat (5) @(negedge clk);
                sto_tready = 1'b1;
            end
            send(32'h41, 1'b0);
        join
        chk("t3_n2_run", run, 0);
        send(32'h42, 1'b0);
        chk("t3_n3_run", run, 1);
        chk("t3_n3_data", sto_tdata, 32'h42);

        // ---- priority between simultaneous matches, ignored stage index
        set_stage(0, 32'h0F, 32'h77, 32'h8800_0001);
        set_stage(2, 32'h0F, 32'h07, 32'h8800_0000);
        cfg_wr(4, 1, 32'h0);
        pulse(1'b1, 1'b0);
        send(32'h77, 1'b0);
        chk("t4_win0_norun", run, 0);
        chk("t4_win0_delay", sts_armed, 1);
        send(32'h00, 1'b0);
        chk("t4_fire", run, 1);
        pulse(1'b1, 1'b1);
        chk("t4_clr_wins", sts_armed, 0);
        pulse(1'b1, 1'b0);
        chk("t4_rearm", sts_armed, 1);

        // ---- level saturation
        for (int i = 0; i < STN; i++) set_stage(i, 32'h0, 32'h0, 32'h8000_0000 | (i << 16));
        pulse(1'b1, 1'b0);
        send(32'h1, 1'b0);
        chk("t5_lvl1", sts_level, 1);
        send(32'h2, 1'b0);
        send(32'h3, 1'b0);
        chk("t5_lvl3", sts_level, 3);
        send(32'h4, 1'b0);
        send(32'h5, 1'b0);
        chk("t5_lvl_sat", sts_level, 3);

        // ---- random valid/ready throughput, trigger idle
        pulse(1'b0, 1'b1);
        start_acc = n_acc;
        ok = 1'b0;
        for (int cyc = 0; cyc < 20000 && !ok; cyc++) begin
            @(negedge clk);
            if (n_acc >= start_acc + 1000) begin
                ok = 1'b1;
                sti_tvalid = 1'b0;
            end else if (!sti_tvalid || m_hs) begin
                sti_tvalid = ($urandom_range(0, 3) != 0);
                sti_tdata  = $urandom;
                sti_tlast  = ($urandom_range(0, 7) == 0);
            end
            sto_tready = ($urandom_range(0, 3) != 0);
        end
        sti_tvalid = 1'b0;
        if (!ok) begin
            checks++;
            fails++;
            $display("FAIL stream_budget: accepted %0d of 1000 samples", n_acc - start_acc);
        end
        @(negedge clk);
        sto_tready = 1'b1;
        @(negedge clk);

        // ---- asynchronous reset drops the registered sample
        sto_tready = 1'b0;
        send(32'hDEAD_BEEF, 1'b1);
        chk("t7_held", sto_tvalid, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("t7_rst_tvalid", sto_tvalid, 0);
        chk("t7_rst_level", sts_level, 0);
        @(negedge clk);
        rst = 1'b1;
        sto_tready = 1'b1;

`ifdef TRIGGER_SEQ_EDGE_EN
        // ---- edge-qualified stage
        set_stage(0, 32'h80, 32'h80, 32'h9800_0000);
        pulse(1'b1, 1'b0);
        send(32'h80, 1'b0);
        chk("e_first", run, 1);
        pulse(1'b1, 1'b0);
        send(32'h80, 1'b0);
        chk("e_second", run, 0);
        send(32'h00, 1'b0);
        chk("e_third", run, 0);
        send(32'h80, 1'b0);
        chk("e_fourth", run, 1);
`endif

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/trigger_seq.md
Name: trigger_seq

Overview:
- Parametrised multi-stage sequential trigger; successor to the fixed basic trigger in the capture core.
- Sits between sampler and shifter on the sample stream.
- Passes the stream through with one register stage and tags the sample at which the trigger fires.
- STN stages, each with its own mask, value, level, delay and start flag; firing requires stages to match in level order.

Parameters:
- SDW, 32, sample data width.
- STN, 4, number of trigger stages (1..8).
- DLW, 16, delay counter width in samples.
- LVW, 2, level field width; needs 2**LVW >= STN.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-low (asserted at 0)
- cfg_stg  input  3  stage index for the configuration write
- cfg_wr_mask  input  1  write cfg_data[SDW-1:0] to mask[cfg_stg]
- cfg_wr_val  input  1  write cfg_data[SDW-1:0] to value[cfg_stg]
- cfg_wr_cfg  input  1  write the stage config word
- cfg_data  input  32  configuration data
- ctl_arm  input  1  pulse: clear level and delay, enter ARMED
- ctl_clr  input  1  pulse: return to IDLE
- sti_tready  output  1  input ready
- sti_tvalid  input  1  input valid
- sti_tlast  input  1  input last
- sti_tdata  input  SDW  input sample
- sto_tready  input  1  output ready
- sto_tvalid  output  1  output valid
- sto_tlast  output  1  output last
- sto_trigger  output  1  marks the sample on which the trigger fired
- sto_tdata  output  SDW  output sample
- run  output  1  one-cycle pulse when the trigger fires
- sts_level  output  LVW  current level
- sts_armed  output  1  state is ARMED or DELAY

Behaviour:
- Config word layout:
  - [DLW-1:0] delay
  - [17:16] level
  - [27] start
  - [28] edge
  - [31] enable
- Config writes are accepted in any state. A cfg_stg value >= STN is ignored.
- Reset values:
  - all stage registers 0
  - state IDLE, level 0, delay counter 0
  - sto_tvalid=0, run=0, sto_trigger=0, sts_armed=0
- Stream path:
  - One-deep output register; latency 1 cycle.
  - sti_tready = !sto_tvalid | sto_tready, so a transfer can happen every cycle at full throughput.
  - Data and tlast are forwarded unchanged. Stream state is the same in every trigger state.
- Match for stage i, evaluated only on an input handshake (sti_tvalid & sti_tready):
  - enable[i], AND
  - level[i] == current level, AND
  - ((sti_tdata ^ value[i]) & mask[i]) == 0.
- States:
  - IDLE: no matching. ctl_arm moves to ARMED.
  - ARMED: on a handshake with any match, the lowest-index matching stage wins.
    - Load the delay counter with delay[winner] and latch the winner index.
    - If delay == 0, take the expiry action on the same sample. Otherwise go to DELAY.
  - DELAY: decrement on each handshake; do not decrement on idle cycles. Reaching 0 is expiry.
  - Expiry action:
    - If start[winner]: assert run for 1 cycle, set sto_trigger on that same sample in the output register, go to FIRED.
    - Otherwise: level = level + 1, return to ARMED.
    - Level saturates at 2**LVW-1.
  - FIRED: hold. ctl_arm re-arms; ctl_clr goes to IDLE.
- Priority when events coincide: ctl_clr > ctl_arm > match/expiry.
- ctl_arm in any state clears level and delay and enters ARMED.
- Asynchronous reset mid-operation drops the registered sample; sto_tvalid returns to 0.
- Backpressure: while sto_tready=0, no handshake occurs, so matching and the delay counter freeze.

Optional Feature:
- Macro: TRIGGER_SEQ_EDGE_EN.
- Defined:
  - Keep a previous-accepted-sample register, reset to 0.
  - A stage with edge=1 matches only if the current sample matches and the previous accepted sample did not match under the same mask/value.
  - The previous-sample register updates on every handshake in every state.
- Undefined: edge bit ignored; matching is level-only; no previous-sample register exists.

Decomposition:
- Package trigger_pkg holds:
  - config-word field bit positions
  - state encoding constants: IDLE, ARMED, DELAY, FIRED
- Sub-module trigger_stage (one per stage, via generate):
  - holds mask, value and config registers
  - produces the match bit (and the edge compare when the macro is defined)
- The top level holds the priority encoder, FSM, delay counter and stream register.

Test Plan:
- Stage0 mask=0xFF, val=0x5A, level 0, delay 0, start 1; arm; send 0x00, 0x11, 0x5A -> run pulses one cycle after the 0x5A handshake; sto_trigger=1 only on 0x5A; state FIRED.
- Two-level sequence:
  - Stage0 val=0x01, start 0, level 0. Stage1 val=0x02, start 1, level 1.
  - Send 02, 01, 02 -> the first 02 is ignored; sts_level becomes 1 after 01; fire on the second 02.
- Delay: stage0 delay=3, start 1; match on sample N -> fire on sample N+3. With sto_tready low for 5 cycles mid-delay, fire still lands on sample N+3 (no cycle counting).
- Simultaneous match of stages 0 and 2 at level 0 -> stage 0 wins and its delay/start are used. Then ctl_arm together with ctl_clr -> state IDLE.
- Stream throughput: random valid/ready for 1000 samples -> output equals input in order, with no loss or duplication; tlast preserved.
- With TRIGGER_SEQ_EDGE_EN, stage0 edge=1 val=0x80 mask=0x80; send 80, 80, 00, 80 -> fire on the first 80 only if the previous sample (reset value 00) mismatched; with re-arm after the first fire, the next fire is on the 4th sample, not the 2nd.
